// File: rtl/mvm_stream_loader_if.sv
// Stream/core-side bus of the MVM stream loader.
//
// Groups the job command handshake, the inbound word stream and the
// matrix-vector core load/start/done signals into one bundle.
//   slave  : loader side (mvm_stream_loader)
//   master : stream source + core side (driver / testbench)
//
// Signals
//   cmd_valid, cmd_matrix -> loader   job request, 1 = matrix then vector
//   cmd_ready             <- loader   loader idle
//   s_valid, s_data       -> loader   stream word (row-major matrix, then vector)
//   s_ready               <- loader   stream word accepted this cycle
//   loadMatrix/loadVector <- loader   one-cycle pulses announcing a burst
//   start                 <- loader   one-cycle pulse to the core
//   data_out              <- loader   burst word to core data_in
//   done                  -> loader   core done pulse
//   job_done, err         <- loader   job finished / watchdog expiry pulses
interface mvm_stream_loader_if #(
    parameter int B = 16
);
    logic                cmd_valid;
    logic                cmd_matrix;
    logic                cmd_ready;
    logic                s_valid;
    logic signed [B-1:0] s_data;
    logic                s_ready;
    logic                loadMatrix;
    logic                loadVector;
    logic                start;
    logic signed [B-1:0] data_out;
    logic                done;
    logic                job_done;
    logic                err;

    modport slave (
        input  cmd_valid, cmd_matrix, s_valid, s_data, done,
        output cmd_ready, s_ready, loadMatrix, loadVector, start, data_out,
               job_done, err
    );

    modport master (
        output cmd_valid, cmd_matrix, s_valid, s_data, done,
        input  cmd_ready, s_ready, loadMatrix, loadVector, start, data_out,
               job_done, err
    );
endinterface

// File: rtl/mvm_stream_loader.sv
// Upstream feeder for the K x K matrix-vector multiply core.
//
// Buffers each stream segment (K*K matrix words, then K vector words) in a
// single register array, then replays it gap-free to the core: a load pulse,
// followed by one word per cycle. Afterwards it pulses start and waits for
// the core's done. The stream source may stall freely while filling.
//
// Parameters
//   K     matrix dimension (K >= 2)
//   B     data word width (signed)
//   WDOG  done-wait limit in cycles (only with MVM_LOADER_WDOG_EN)
//
// Ports
//   clk    clock
//   reset  synchronous active-high reset (aborts any job)
//   bus    mvm_stream_loader_if.slave: command, stream and core signals
//
// Optional feature: define MVM_LOADER_WDOG_EN to enable the done watchdog.
// err pulses when WDOG cycles pass in WAIT without done; otherwise err is 0
// and WAIT holds until done.
module mvm_stream_loader #(
    parameter int K    = 8,
    parameter int B    = 16,
    parameter int WDOG = 64
) (
    input  logic               clk,
    input  logic               reset,
    mvm_stream_loader_if.slave bus
);
    localparam int MLEN = K * K;
    localparam int AW   = $clog2(MLEN);
    localparam int CW   = $clog2(MLEN + 1);

    localparam logic [CW-1:0] M_LAST = CW'(MLEN - 1);
    localparam logic [CW-1:0] V_LAST = CW'(K - 1);
    localparam logic [CW-1:0] M_LEN  = CW'(MLEN);
    localparam logic [CW-1:0] V_LEN  = CW'(K);

    typedef enum logic [3:0] {
        IDLE, FILL_M, GAP_M, BURST_M, GAP, FILL_V, GAP_V, BURST_V, GAP_S,
        START, WAIT
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       fill_idx, fill_idx_nx;
    logic [CW-1:0]       burst_idx, burst_idx_nx;
    logic signed [B-1:0] mem [MLEN];
    logic                wr_en;
    logic                wdog_hit;

    logic                cmd_ready, s_ready, load_m, load_v, start_p;
    logic                job_done_p, err_p;
    logic signed [B-1:0] data_o;

    // Control state; the buffer is data and carries no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fill_idx  <= '0;
            burst_idx <= '0;
        end else begin
            state     <= state_nx;
            fill_idx  <= fill_idx_nx;
            burst_idx <= burst_idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[AW'(fill_idx)] <= bus.s_data;
    end

`ifdef MVM_LOADER_WDOG_EN
    localparam int WW = $clog2(WDOG + 1);
    logic [WW-1:0] wdog_cnt;

    // Counts cycles spent in WAIT; value k in the k-th cycle after entry.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) wdog_cnt <= '0;
        else if (wdog_cnt != WW'(WDOG)) wdog_cnt <= wdog_cnt + WW'(1);
    end

    assign wdog_hit = (state == WAIT) && (wdog_cnt == WW'(WDOG));
`else
    // No watchdog: WAIT holds until done and WDOG has no effect.
    assign wdog_hit = (WDOG < 0);
`endif

    always_comb begin
        state_nx     = state;
        fill_idx_nx  = fill_idx;
        burst_idx_nx = burst_idx;
        wr_en        = 1'b0;
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        load_m       = 1'b0;
        load_v       = 1'b0;
        start_p      = 1'b0;
        job_done_p   = 1'b0;
        err_p        = 1'b0;
        data_o       = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = bus.cmd_matrix ? FILL_M : FILL_V;
            end
            FILL_M, FILL_V: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    wr_en = 1'b1;
                    // The index clears on the last word, so it never runs
                    // past the segment into the next one.
                    if (fill_idx == ((state == FILL_M) ? M_LAST : V_LAST)) begin
                        fill_idx_nx = '0;
                        state_nx    = (state == FILL_M) ? GAP_M : GAP_V;
                    end else begin
                        fill_idx_nx = fill_idx + CW'(1);
                    end
                end
            end
            GAP_M: state_nx = BURST_M;
            GAP:   state_nx = FILL_V;
            GAP_V: state_nx = BURST_V;
            GAP_S: state_nx = START;
            BURST_M, BURST_V: begin
                // Index 0 is the load pulse cycle; index i>0 shows word i-1.
                if (burst_idx == '0) begin
                    load_m = (state == BURST_M);
                    load_v = (state == BURST_V);
                end else begin
                    data_o = mem[AW'(burst_idx - CW'(1))];
                end
                if (burst_idx == ((state == BURST_M) ? M_LEN : V_LEN)) begin
                    burst_idx_nx = '0;
                    state_nx     = (state == BURST_M) ? GAP : GAP_S;
                end else begin
                    burst_idx_nx = burst_idx + CW'(1);
                end
            end
            START: begin
                start_p  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                // done wins over a watchdog expiry in the same cycle.
                if (bus.done) begin
                    job_done_p = 1'b1;
                    state_nx   = IDLE;
                end else if (wdog_hit) begin
                    err_p    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.s_ready    = s_ready;
    assign bus.loadMatrix = load_m;
    assign bus.loadVector = load_v;
    assign bus.start      = start_p;
    assign bus.data_out   = data_o;
    assign bus.job_done   = job_done_p;
    assign bus.err        = err_p;
endmodule

// File: tb/tb_mvm_stream_loader.sv
// Testbench for mvm_stream_loader (K=2, B=16, WDOG=10).
// Expected core-side events are queued when a job is issued; a monitor on
// the falling edge pops and compares every event the loader presents.
module tb_mvm_stream_loader;
    localparam int K    = 2;
    localparam int B    = 16;
    localparam int WDOG = 10;
    localparam int ML   = K * K;
`ifdef MVM_LOADER_WDOG_EN
    localparam int MAXD = WDOG;
`else
    localparam int MAXD = 20;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mvm_stream_loader_if #(.B(B)) bus ();
    mvm_stream_loader #(.K(K), .B(B), .WDOG(WDOG)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef enum int {EV_LM, EV_LV, EV_D, EV_ST, EV_JD, EV_ERR} ev_t;
    typedef struct {
        ev_t         k;
        logic [15:0] v;
    } ev_s;

    ev_s exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  win_left = 0;
    int  d_seen = 0, st_seen = 0, jd_seen = 0, err_seen = 0;
    int  st_cyc = 0, err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input ev_t k, input logic [15:0] v);
        ev_s e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got %s/%0d, required no event (cycle %0d)", k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.v !== v) begin
                bad++;
                $display("FAIL event: got %s/%0d, required %s/%0d (cycle %0d)",
                         k.name(), v, e.k.name(), e.v, cyc);
            end
        end
    endtask

    // Monitor: after a load pulse the next len cycles are data words.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (win_left > 0) begin
                    expect_ev(EV_D, bus.data_out);
                    chk("burst_pulses", {27'd0, bus.loadMatrix, bus.loadVector, bus.start,
                                         bus.job_done, bus.err}, 32'd0);
                    d_seen++;
                    win_left--;
                end else begin
                    if (bus.loadMatrix) begin expect_ev(EV_LM, 16'd0); win_left = ML; end
                    if (bus.loadVector) begin expect_ev(EV_LV, 16'd0); win_left = K; end
                    if (bus.start) begin expect_ev(EV_ST, 16'd0); st_seen++; st_cyc = cyc; end
                    if (bus.job_done) begin expect_ev(EV_JD, 16'd0); jd_seen++; end
                    if (bus.err) begin expect_ev(EV_ERR, 16'd0); err_seen++; err_cyc = cyc; end
                    chk("idle_data", {16'd0, bus.data_out}, 32'd0);
                end
            end
        end
    end

    // Reference: a job produces its load/data/start event list.
    task automatic push_job(input bit m, input logic [15:0] w[$]);
        int base;
        base = 0;
        if (m) begin
            exp_q.push_back('{EV_LM, 16'd0});
            for (int i = 0; i < ML; i++) exp_q.push_back('{EV_D, w[i]});
            base = ML;
        end
        exp_q.push_back('{EV_LV, 16'd0});
        for (int i = 0; i < K; i++) exp_q.push_back('{EV_D, w[base + i]});
        exp_q.push_back('{EV_ST, 16'd0});
    endtask

    task automatic issue_cmd(input bit m);
        bus.cmd_valid = 1'b1;
        bus.cmd_matrix = m;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // mode 0: s_valid held, 1: toggles 1/0, 2: random stalls.
    task automatic send_word(input logic [15:0] w, input int mode);
        int n;
        if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data = w;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL s_ready_timeout: got 0 for %0d cycles, required 1", n);
                @(posedge clk); #1;
                bus.s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_words(input logic [15:0] w[$], input int first, input int cnt,
                              input int mode);
        for (int i = first; i < first + cnt; i++) send_word(w[i], mode);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int st0;
        int n;
        st0 = st_seen;
        n = 0;
        while (st_seen == st0 && n < 400) begin @(posedge clk); #1; n++; end
        ok = (st_seen != st0);
        chk("start_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic core_done_after(input int dly);
        int jd0;
        repeat (dly) begin @(posedge clk); #1; end
        exp_q.push_back('{EV_JD, 16'd0});
        jd0 = jd_seen;
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        chk("job_done_seen", jd_seen - jd0, 32'd1);
    endtask

    task automatic run_job(input bit m, input logic [15:0] w[$], input int mode, input int dly);
        bit ok;
        issue_cmd(m);
        push_job(m, w);
        send_words(w, 0, m ? ML + K : K, mode);
        wait_start(ok);
        if (ok) core_done_after(dly);
    endtask

    initial begin
        logic [15:0] w[$];
        bit ok;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_matrix = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_pulses", {27'd0, bus.loadMatrix, bus.loadVector, bus.start,
                           bus.job_done, bus.err}, 32'd0);
        chk("rst_data", {16'd0, bus.data_out}, 32'd0);
        @(posedge clk); #1;

        // Matrix + vector, continuous stream
        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        run_job(1'b1, w, 0, MAXD);

        // Same job, s_valid toggling
        run_job(1'b1, w, 1, MAXD);

        // Vector only
        w = '{16'd7, 16'd8};
        run_job(1'b0, w, 0, 5);

        // Reset in the middle of the matrix burst
        w = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
        issue_cmd(1'b1);
        push_job(1'b1, w);
        send_words(w, 0, ML, 0);
        n = d_seen;
        begin
            int t;
            t = 0;
            while (d_seen == n && t < 100) begin @(posedge clk); #1; t++; end
            chk("burst_word_seen", {31'd0, d_seen != n}, 32'd1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        win_left = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_pulses", {27'd0, bus.loadMatrix, bus.loadVector, bus.start,
                             bus.job_done, bus.err}, 32'd0);
        chk("abort_data", {16'd0, bus.data_out}, 32'd0);
        repeat (12) begin @(posedge clk); #1; end
        w = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h1234, 16'hABCD};
        run_job(1'b1, w, 0, 4);

        // done during FILL_V is ignored; cmd_valid during WAIT is ignored
        w = '{16'd21, 16'd22};
        issue_cmd(1'b0);
        push_job(1'b0, w);
        bus.done = 1'b1;
        @(negedge clk);
        chk("fill_done_ignored", {31'd0, bus.job_done}, 32'd0);
        @(posedge clk); #1;
        bus.done = 1'b0;
        send_words(w, 0, K, 0);
        wait_start(ok);
        if (ok) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_matrix = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("wait_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
                @(posedge clk); #1;
            end
            bus.cmd_valid = 1'b0;
            core_done_after(2);
            @(negedge clk);
            chk("post_job_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
            @(posedge clk); #1;
        end

        // Core never raises done
        w = '{16'd31, 16'd32};
        issue_cmd(1'b0);
        push_job(1'b0, w);
        send_words(w, 0, K, 0);
        wait_start(ok);
        if (ok) begin
`ifdef MVM_LOADER_WDOG_EN
            exp_q.push_back('{EV_ERR, 16'd0});
            n = err_seen;
            begin
                int t;
                t = 0;
                while (err_seen == n && t < 60) begin @(posedge clk); #1; t++; end
            end
            chk("err_seen", err_seen - n, 32'd1);
            chk("err_latency", err_cyc - st_cyc, WDOG + 1);
            @(negedge clk);
            chk("err_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
            @(posedge clk); #1;

            // done exactly at expiry counts as success
            w = '{16'd41, 16'd42};
            issue_cmd(1'b0);
            push_job(1'b0, w);
            send_words(w, 0, K, 0);
            wait_start(ok);
            if (ok) core_done_after(st_cyc + WDOG + 1 - cyc);
`else
            repeat (30) begin
                @(negedge clk);
                chk("hold_err", {31'd0, bus.err}, 32'd0);
                chk("hold_wait", {31'd0, bus.cmd_ready}, 32'd0);
                @(posedge clk); #1;
            end
            core_done_after(0);
`endif
        end

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            bit m;
            m = $urandom_range(1, 0) == 1;
            w.delete();
            for (int i = 0; i < ML + K; i++) w.push_back(16'($urandom));
            run_job(m, w, 2, $urandom_range(MAXD, 1));
        end

        repeat (10) begin @(posedge clk); #1; end
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
